// File: rtl/bcd_display_conv_if.sv
// Handshake and result bundle between the register-file read port, the
// binary-to-BCD converter and the seven-segment digit decoders.
interface bcd_display_conv_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  out_valid;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;
    logic                  busy;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  bcd,
        input  blank,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output bcd,
        output blank,
        output busy
    );
endinterface

// File: rtl/bcd_display_conv.sv
// Sequential double-dabble converter: one 16-bit value per handshake, one
// shift-and-add-3 iteration per clock, registered BCD digits plus blanking mask.
module bcd_display_conv #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input logic               clk,
    input logic               rst_n,
    bcd_display_conv_if.slave bus
);

    localparam int                  BCD_W     = 4 * DIGITS;
    localparam int                  CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [DIGITS-1:0]   BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    bin_q;
    logic [BCD_W-1:0]    scratch_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [DIGITS-1:0]   blank_q;
    logic                out_valid_q;

    logic [BCD_W-1:0]    scratch_adj_d;
    logic [BCD_W-1:0]    scratch_d;
    logic [WIDTH-1:0]    bin_d;

    function automatic logic [3:0] add3(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

    // A digit blanks only when it and every more significant digit are zero;
    // the units digit always shows so that zero renders as "0".
    function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] s);
        logic [DIGITS-1:0] m;
        logic              all_zero;
        all_zero = 1'b1;
        m        = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (s[4*i +: 4] == 4'd0);
            m[i]     = all_zero;
        end
        m[0] = 1'b0;
        return m;
    endfunction

    always_comb begin
        scratch_adj_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            scratch_adj_d[4*i +: 4] = add3(scratch_q[4*i +: 4]);
        end
        {scratch_d, bin_d} = {scratch_adj_d, bin_q} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            blank_q     <= BLANK_RST;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        bin_q     <= bus.in_data;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= CONV;
                    end
                end
                CONV: begin
                    bin_q     <= bin_d;
                    scratch_q <= scratch_d;
                    cnt_q     <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_q       <= scratch_q;
                    blank_q     <= blank_mask(scratch_q);
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.bcd       = bcd_q;
    assign bus.blank     = blank_q;

endmodule

// File: tb/tb_bcd_display_conv.sv
// Bench for bcd_display_conv: vector table and random values through a
// scoreboard, plus timed sequences for latency, busy-ignore, reset and streaming.
module tb_bcd_display_conv;

    typedef struct {
        logic [15:0] din;
        logic [19:0] bcd;
        logic [4:0]  blank;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    vec_t sb[$];

    always #5 clk = ~clk;

    bcd_display_conv_if #(.WIDTH(16), .DIGITS(5)) bus ();

    bcd_display_conv #(.WIDTH(16), .DIGITS(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [19:0] model_bcd(input int v);
        logic [19:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] model_blank(input int v);
        logic [4:0] b;
        int nd;
        int t;
        nd = 1;
        t  = v / 10;
        while (t > 0) begin
            nd++;
            t = t / 10;
        end
        for (int i = 0; i < 5; i++) b[i] = (i >= nd);
        return b;
    endfunction

    // Scoreboard side: every out_valid pulse pops one expected result.
    logic        prev_ov   = 1'b0;
    logic [19:0] last_bcd  = 20'h0;
    logic [4:0]  last_blank = 5'b11110;
    always @(negedge clk) begin
        vec_t e;
        if (!rst_n) begin
            prev_ov    = 1'b0;
            last_bcd   = 20'h0;
            last_blank = 5'b11110;
        end else begin
            if (bus.out_valid) begin
                checks++;
                if (prev_ov) begin
                    failures++;
                    $display("FAIL ov_pulse_width: out_valid high two cycles in a row");
                end
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out_valid: bcd=%h blank=%b, none expected", bus.bcd, bus.blank);
                end else begin
                    e = sb.pop_front();
                    if (bus.bcd !== e.bcd || bus.blank !== e.blank) begin
                        failures++;
                        $display("FAIL result(%0d): got bcd=%h blank=%b, want bcd=%h blank=%b",
                                 e.din, bus.bcd, bus.blank, e.bcd, e.blank);
                    end
                end
                last_bcd   = bus.bcd;
                last_blank = bus.blank;
            end else begin
                checks++;
                if (bus.bcd !== last_bcd || bus.blank !== last_blank) begin
                    failures++;
                    $display("FAIL hold: bcd=%h blank=%b changed without out_valid, want %h %b",
                             bus.bcd, bus.blank, last_bcd, last_blank);
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [15:0] d);
        vec_t e;
        e.din   = d;
        e.bcd   = model_bcd(int'(d));
        e.blank = model_blank(int'(d));
        sb.push_back(e);
    endtask

    // Returns #1 after the handshake edge E0 with in_valid dropped.
    task automatic handshake(input logic [15:0] d, input bit expect_out);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("hs_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        if (expect_out) push_exp(d);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    vec_t vecs[11];
    int   ov_cyc[3];

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 16'd0;

        vecs[0]  = '{16'd0,     20'h00000, 5'b11110};
        vecs[1]  = '{16'd1597,  20'h01597, 5'b10000};
        vecs[2]  = '{16'd46368, 20'h46368, 5'b00000};
        vecs[3]  = '{16'd9,     20'h00009, 5'b11110};
        vecs[4]  = '{16'd10,    20'h00010, 5'b11100};
        vecs[5]  = '{16'd99,    20'h00099, 5'b11100};
        vecs[6]  = '{16'd100,   20'h00100, 5'b11000};
        vecs[7]  = '{16'd999,   20'h00999, 5'b11000};
        vecs[8]  = '{16'd1000,  20'h01000, 5'b10000};
        vecs[9]  = '{16'd9999,  20'h09999, 5'b10000};
        vecs[10] = '{16'd10000, 20'h10000, 5'b00000};

        // Asynchronous reset with no clock edge in between.
        #3 rst_n = 1'b0;
        #1;
        check("rst_bcd",       32'(bus.bcd),       32'h0);
        check("rst_blank",     32'(bus.blank),     32'b11110);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_busy",      32'(bus.busy),      32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Full scale with cycle-exact latency.
        handshake(16'd65535, 1'b1);
        check("fs_ready_e0", 32'(bus.in_ready), 32'd0);
        for (int n = 1; n <= 17; n++) begin
            @(posedge clk);
            #1;
            if (n < 17) begin
                check("fs_ready_low", 32'(bus.in_ready),  32'd0);
                check("fs_busy",      32'(bus.busy),      32'd1);
                check("fs_no_ov",     32'(bus.out_valid), 32'd0);
            end else begin
                check("fs_ov_e17",    32'(bus.out_valid), 32'd1);
                check("fs_ready_e17", 32'(bus.in_ready),  32'd1);
                check("fs_bcd",       32'(bus.bcd),       32'h65535);
                check("fs_blank",     32'(bus.blank),     32'b00000);
            end
        end
        @(posedge clk);
        #1 check("fs_ov_e18", 32'(bus.out_valid), 32'd0);
        wait_drain();

        // Table vectors: constants in the table, checked by the scoreboard too.
        for (int k = 0; k < 11; k++) begin
            handshake(vecs[k].din, 1'b1);
            wait_drain();
            check("tbl_bcd",   32'(bus.bcd),   32'(vecs[k].bcd));
            check("tbl_blank", 32'(bus.blank), 32'(vecs[k].blank));
        end

        for (int k = 0; k < 6; k++) begin
            handshake(16'($urandom_range(0, 65535)), 1'b1);
            wait_drain();
        end

        // in_valid held through the conversion: second value taken at E18.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd12345;
        push_exp(16'd12345);
        push_exp(16'd42);
        @(posedge clk);
        #1 bus.in_data = 16'd42;
        for (int n = 1; n <= 35; n++) begin
            @(posedge clk);
            #1;
            if (n == 17) begin
                check("bi_ov1",  32'(bus.out_valid), 32'd1);
                check("bi_bcd1", 32'(bus.bcd),       32'h12345);
            end
            if (n == 18) check("bi_busy_e18", 32'(bus.busy), 32'd1);
            if (n == 35) begin
                check("bi_ov2",    32'(bus.out_valid), 32'd1);
                check("bi_bcd2",   32'(bus.bcd),       32'h00042);
                check("bi_blank2", 32'(bus.blank),     32'b11100);
            end
        end
        bus.in_valid = 1'b0;
        wait_drain();

        // Reset in the middle of a conversion discards it.
        handshake(16'd7, 1'b1);
        wait_drain();
        handshake(16'd9999, 1'b0);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mr_bcd",      32'(bus.bcd),       32'h0);
        check("mr_blank",    32'(bus.blank),     32'b11110);
        check("mr_ready",    32'(bus.in_ready),  32'd1);
        check("mr_busy",     32'(bus.busy),      32'd0);
        check("mr_ov",       32'(bus.out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("mr_bcd_after", 32'(bus.bcd), 32'h0);
        handshake(16'd10, 1'b1);
        wait_drain();
        check("mr_bcd10",   32'(bus.bcd),   32'h00010);
        check("mr_blank10", 32'(bus.blank), 32'b11100);

        // Back-to-back stream 1, 2, 3 with in_valid held high.
        begin
            int idx;
            int nov;
            int cyc;
            logic hs;
            idx = 0;
            nov = 0;
            cyc = 0;
            push_exp(16'd1);
            push_exp(16'd2);
            push_exp(16'd3);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.in_data  = 16'd1;
            for (int n = 0; n < 80; n++) begin
                @(negedge clk);
                hs = bus.in_ready && bus.in_valid;
                @(posedge clk);
                cyc++;
                #1;
                if (hs) begin
                    idx++;
                    if (idx == 3) bus.in_valid = 1'b0;
                    else bus.in_data = 16'(idx + 1);
                end
                if (bus.out_valid && nov < 3) begin
                    ov_cyc[nov] = cyc;
                    nov++;
                end
            end
            bus.in_valid = 1'b0;
            check("b2b_count", 32'(nov), 32'd3);
            if (nov == 3) begin
                check("b2b_gap1", 32'(ov_cyc[1] - ov_cyc[0]), 32'd18);
                check("b2b_gap2", 32'(ov_cyc[2] - ov_cyc[1]), 32'd18);
            end
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
